// File: rtl/half_pwm_cap_pkg.sv
// Shared types and constants for the half-bridge PWM capture monitor.
package half_pwm_cap_pkg;

    localparam int unsigned CAP_RAM_WIDTH = 32;
    localparam int unsigned STATE_W       = 3;

    localparam logic [CAP_RAM_WIDTH-1:0] CAP_SAT_MAX = {CAP_RAM_WIDTH{1'b1}};

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_GAP_A  = 3'd1;
    localparam logic [STATE_W-1:0] ST_HIGH_A = 3'd2;
    localparam logic [STATE_W-1:0] ST_GAP_B  = 3'd3;
    localparam logic [STATE_W-1:0] ST_HIGH_B = 3'd4;

    typedef enum logic [1:0] {
        CNT_HOLD  = 2'd0,
        CNT_CLEAR = 2'd1,
        CNT_LOAD1 = 2'd2,
        CNT_INC   = 2'd3
    } cnt_op_e;

    // All-ones value for a counter of the given width (width up to CAP_RAM_WIDTH).
    function automatic logic [CAP_RAM_WIDTH-1:0] sat_max(input int unsigned width);
        return CAP_SAT_MAX >> (CAP_RAM_WIDTH - width);
    endfunction

endpackage

// File: rtl/pwm_sat_counter.sv
// Working interval counter: clear, load-1 or saturating increment.
// sat_hit is high in the cycle an increment lands on all-ones.
module pwm_sat_counter
    import half_pwm_cap_pkg::*;
#(
    parameter int unsigned W = CAP_RAM_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  cnt_op_e      op,
    output logic [W-1:0] cnt,
    output logic         sat_hit
);

    localparam logic [W-1:0] ONES = W'(sat_max(W));
    localparam logic [W-1:0] ZERO = {W{1'b0}};
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // next count; an increment sticks once all-ones is reached
    always_comb begin
        cnt_d   = cnt_q;
        sat_hit = 1'b0;
        case (op)
            CNT_HOLD:  cnt_d = cnt_q;
            CNT_CLEAR: cnt_d = ZERO;
            CNT_LOAD1: cnt_d = ONE;
            CNT_INC: begin
                if (cnt_q != ONES) begin
                    cnt_d   = cnt_q + ONE;
                    sat_hit = ((cnt_q + ONE) == ONES);
                end else begin
                    cnt_d   = cnt_q;
                    sat_hit = 1'b0;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/half_pwm_capture.sv
// Half-bridge gate monitor: measures dead/high intervals of A and B per frame and flags
// overlap, ordering and saturation. Macro HALF_PWM_CAPTURE_SYNC_EN adds a 2-flop input synchroniser.
module half_pwm_capture
    import half_pwm_cap_pkg::*;
#(
    parameter int unsigned _RAM_WIDTH = CAP_RAM_WIDTH
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  io_en,
    input  logic                  io_defaultLevel,
    input  logic                  io_pulseIn_a,
    input  logic                  io_pulseIn_b,
    output logic [_RAM_WIDTH-1:0] die_a_cnt,
    output logic [_RAM_WIDTH-1:0] pulse_a_cnt,
    output logic [_RAM_WIDTH-1:0] die_b_cnt,
    output logic [_RAM_WIDTH-1:0] pulse_b_cnt,
    output logic                  meas_valid,
    output logic                  overlap_err,
    output logic                  seq_err,
    output logic                  sat_err
);

    localparam logic [_RAM_WIDTH-1:0] ZERO = {_RAM_WIDTH{1'b0}};

    logic a_d, b_d, a_q, b_q;

`ifdef HALF_PWM_CAPTURE_SYNC_EN
    logic [1:0] sync_a_d, sync_a_q, sync_b_d, sync_b_q;

    // synchroniser shift and normalisation of its output
    always_comb begin
        sync_a_d = {sync_a_q[0], io_pulseIn_a};
        sync_b_d = {sync_b_q[0], io_pulseIn_b};
        a_d      = sync_a_q[1] ^ io_defaultLevel;
        b_d      = sync_b_q[1] ^ io_defaultLevel;
    end

    // synchroniser flops park at the inactive level so reset never looks like an edge
    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            sync_a_q <= {2{io_defaultLevel}};
            sync_b_q <= {2{io_defaultLevel}};
        end else begin
            sync_a_q <= sync_a_d;
            sync_b_q <= sync_b_d;
        end
    end
`else
    // direct normalisation: 1 means active regardless of gate polarity
    always_comb begin
        a_d = io_pulseIn_a ^ io_defaultLevel;
        b_d = io_pulseIn_b ^ io_defaultLevel;
    end
`endif

    logic [STATE_W-1:0]    state_d, state_q;
    cnt_op_e               cnt_op;
    logic [_RAM_WIDTH-1:0] cnt;
    logic                  sat_hit;
    logic [_RAM_WIDTH-1:0] die_a_w_d, die_a_w_q, pulse_a_w_d, pulse_a_w_q, die_b_w_d, die_b_w_q;
    logic [_RAM_WIDTH-1:0] die_a_res_d, die_a_res_q, pulse_a_res_d, pulse_a_res_q;
    logic [_RAM_WIDTH-1:0] die_b_res_d, die_b_res_q, pulse_b_res_d, pulse_b_res_q;
    logic                  meas_valid_d, meas_valid_q, overlap_err_d, overlap_err_q;
    logic                  seq_err_d, seq_err_q, sat_err_d, sat_err_q;

    pwm_sat_counter #(
        .W(_RAM_WIDTH)
    ) u_work_cnt (
        .clk    (io_clk),
        .rst    (io_rst),
        .op     (cnt_op),
        .cnt    (cnt),
        .sat_hit(sat_hit)
    );

    // phase sequencing; the shared counter always holds the current phase length
    always_comb begin
        state_d       = state_q;
        cnt_op        = CNT_HOLD;
        die_a_w_d     = die_a_w_q;
        pulse_a_w_d   = pulse_a_w_q;
        die_b_w_d     = die_b_w_q;
        die_a_res_d   = die_a_res_q;
        pulse_a_res_d = pulse_a_res_q;
        die_b_res_d   = die_b_res_q;
        pulse_b_res_d = pulse_b_res_q;
        meas_valid_d  = 1'b0;
        overlap_err_d = 1'b0;
        seq_err_d     = 1'b0;
        if (!io_en) begin
            state_d = ST_IDLE;
            cnt_op  = CNT_CLEAR;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_GAP_A;
            cnt_op  = CNT_CLEAR;
        end else if (a_q && b_q) begin
            overlap_err_d = 1'b1;
            state_d       = ST_GAP_A;
            cnt_op        = CNT_CLEAR;
            die_a_w_d     = ZERO;
            pulse_a_w_d   = ZERO;
            die_b_w_d     = ZERO;
        end else begin
            case (state_q)
                ST_GAP_A: begin
                    if (a_q) begin
                        die_a_w_d = cnt;
                        state_d   = ST_HIGH_A;
                        cnt_op    = CNT_LOAD1;
                    end else if (b_q) begin
                        seq_err_d = 1'b1;
                        cnt_op    = CNT_CLEAR;
                    end else begin
                        cnt_op = CNT_INC;
                    end
                end
                ST_HIGH_A: begin
                    if (a_q) begin
                        cnt_op = CNT_INC;
                    end else if (b_q) begin
                        pulse_a_w_d = cnt;
                        die_b_w_d   = ZERO;
                        state_d     = ST_HIGH_B;
                        cnt_op      = CNT_LOAD1;
                    end else begin
                        pulse_a_w_d = cnt;
                        state_d     = ST_GAP_B;
                        cnt_op      = CNT_LOAD1;
                    end
                end
                ST_GAP_B: begin
                    if (a_q) begin
                        seq_err_d = 1'b1;
                        die_a_w_d = ZERO;
                        state_d   = ST_HIGH_A;
                        cnt_op    = CNT_LOAD1;
                    end else if (b_q) begin
                        die_b_w_d = cnt;
                        state_d   = ST_HIGH_B;
                        cnt_op    = CNT_LOAD1;
                    end else begin
                        cnt_op = CNT_INC;
                    end
                end
                ST_HIGH_B: begin
                    if (b_q) begin
                        cnt_op = CNT_INC;
                    end else begin
                        die_a_res_d   = die_a_w_q;
                        pulse_a_res_d = pulse_a_w_q;
                        die_b_res_d   = die_b_w_q;
                        pulse_b_res_d = cnt;
                        meas_valid_d  = 1'b1;
                        cnt_op        = CNT_LOAD1;
                        if (a_q) begin
                            die_a_w_d = ZERO;
                            state_d   = ST_HIGH_A;
                        end else begin
                            state_d = ST_GAP_A;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_op  = CNT_CLEAR;
                end
            endcase
        end
    end

    // saturation strobe follows the counter's first arrival at all-ones
    always_comb begin
        sat_err_d = sat_hit;
    end

    // state, samples, working and result registers
    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            state_q       <= ST_IDLE;
            a_q           <= 1'b0;
            b_q           <= 1'b0;
            die_a_w_q     <= ZERO;
            pulse_a_w_q   <= ZERO;
            die_b_w_q     <= ZERO;
            die_a_res_q   <= ZERO;
            pulse_a_res_q <= ZERO;
            die_b_res_q   <= ZERO;
            pulse_b_res_q <= ZERO;
            meas_valid_q  <= 1'b0;
            overlap_err_q <= 1'b0;
            seq_err_q     <= 1'b0;
            sat_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            die_a_w_q     <= die_a_w_d;
            pulse_a_w_q   <= pulse_a_w_d;
            die_b_w_q     <= die_b_w_d;
            die_a_res_q   <= die_a_res_d;
            pulse_a_res_q <= pulse_a_res_d;
            die_b_res_q   <= die_b_res_d;
            pulse_b_res_q <= pulse_b_res_d;
            meas_valid_q  <= meas_valid_d;
            overlap_err_q <= overlap_err_d;
            seq_err_q     <= seq_err_d;
            sat_err_q     <= sat_err_d;
        end
    end

    assign die_a_cnt   = die_a_res_q;
    assign pulse_a_cnt = pulse_a_res_q;
    assign die_b_cnt   = die_b_res_q;
    assign pulse_b_cnt = pulse_b_res_q;
    assign meas_valid  = meas_valid_q;
    assign overlap_err = overlap_err_q;
    assign seq_err     = seq_err_q;
    assign sat_err     = sat_err_q;

endmodule

// File: tb/tb_half_pwm_capture.sv
// Directed bench for half_pwm_capture: a 32-bit instance plus a 4-bit instance for saturation.
module tb_half_pwm_capture;

`ifdef HALF_PWM_CAPTURE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int ENDT = 2 + SYNC_LAT;

    logic        io_clk, io_rst, io_en, io_en4, io_defaultLevel, io_pulseIn_a, io_pulseIn_b;
    logic [31:0] die_a_cnt, pulse_a_cnt, die_b_cnt, pulse_b_cnt;
    logic        meas_valid, overlap_err, seq_err, sat_err;
    logic [3:0]  d4_die_a, d4_pulse_a, d4_die_b, d4_pulse_b;
    logic        d4_mv, d4_ovl, d4_seq, d4_sat;

    int errors = 0;
    int checks = 0;
    int mv_tot = 0, ovl_tot = 0, seq_tot = 0, sat_tot = 0, mv4_tot = 0, sat4_tot = 0;

    half_pwm_capture dut (
        .io_clk(io_clk), .io_rst(io_rst), .io_en(io_en), .io_defaultLevel(io_defaultLevel),
        .io_pulseIn_a(io_pulseIn_a), .io_pulseIn_b(io_pulseIn_b),
        .die_a_cnt(die_a_cnt), .pulse_a_cnt(pulse_a_cnt), .die_b_cnt(die_b_cnt),
        .pulse_b_cnt(pulse_b_cnt), .meas_valid(meas_valid), .overlap_err(overlap_err),
        .seq_err(seq_err), .sat_err(sat_err)
    );

    half_pwm_capture #(._RAM_WIDTH(4)) dut4 (
        .io_clk(io_clk), .io_rst(io_rst), .io_en(io_en4), .io_defaultLevel(io_defaultLevel),
        .io_pulseIn_a(io_pulseIn_a), .io_pulseIn_b(io_pulseIn_b),
        .die_a_cnt(d4_die_a), .pulse_a_cnt(d4_pulse_a), .die_b_cnt(d4_die_b),
        .pulse_b_cnt(d4_pulse_b), .meas_valid(d4_mv), .overlap_err(d4_ovl),
        .seq_err(d4_seq), .sat_err(d4_sat)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    // strobe counters, sampled shortly after each rising edge
    always begin
        @(posedge io_clk);
        #1;
        if (meas_valid)  mv_tot++;
        if (overlap_err) ovl_tot++;
        if (seq_err)     seq_tot++;
        if (sat_err)     sat_tot++;
        if (d4_mv)       mv4_tot++;
        if (d4_sat)      sat4_tot++;
    end

    // normalised drive: a/b = 1 means active; held for n cycles, returns on a falling edge
    task automatic drive(input logic a, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            io_pulseIn_a = a ^ io_defaultLevel;
            io_pulseIn_b = b ^ io_defaultLevel;
            @(negedge io_clk);
        end
    endtask

    task automatic restart();
        io_en = 1'b0;
        drive(1'b0, 1'b0, 4);
        io_en = 1'b1;
    endtask

    task automatic test_reset();
        io_rst = 1'b1;
        drive(1'b0, 1'b0, 3);
        checks++; if (die_a_cnt !== 32'd0 || pulse_a_cnt !== 32'd0) begin errors++;
            $display("FAIL reset_a: die_a=%0d pulse_a=%0d expected 0 0", die_a_cnt, pulse_a_cnt); end
        checks++; if (die_b_cnt !== 32'd0 || pulse_b_cnt !== 32'd0) begin errors++;
            $display("FAIL reset_b: die_b=%0d pulse_b=%0d expected 0 0", die_b_cnt, pulse_b_cnt); end
        checks++; if ({meas_valid, overlap_err, seq_err, sat_err} !== 4'b0000) begin errors++;
            $display("FAIL reset_strobes: got %b expected 0000", {meas_valid, overlap_err, seq_err, sat_err}); end
        checks++; if (d4_pulse_a !== 4'd0 || d4_sat !== 1'b0) begin errors++;
            $display("FAIL reset_w4: pulse_a=%0d sat=%b expected 0 0", d4_pulse_a, d4_sat); end
        io_rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        int mv0;
        mv0 = mv_tot;
        io_en = 1'b1;
        drive(1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 1 + SYNC_LAT);
        checks++; if (meas_valid !== 1'b0) begin errors++;
            $display("FAIL basic_latency_early: meas_valid=%b expected 0", meas_valid); end
        drive(1'b0, 1'b0, 1);
        checks++; if (meas_valid !== 1'b1) begin errors++;
            $display("FAIL basic_latency: meas_valid=%b expected 1", meas_valid); end
        checks++; if (die_a_cnt !== 3 + SYNC_LAT || pulse_a_cnt !== 32'd10) begin errors++;
            $display("FAIL basic_a: die_a=%0d pulse_a=%0d expected %0d 10", die_a_cnt, pulse_a_cnt, 3 + SYNC_LAT); end
        checks++; if (die_b_cnt !== 32'd3 || pulse_b_cnt !== 32'd10) begin errors++;
            $display("FAIL basic_b: die_b=%0d pulse_b=%0d expected 3 10", die_b_cnt, pulse_b_cnt); end
        checks++; if (mv_tot - mv0 !== 1) begin errors++;
            $display("FAIL basic_mv_count: got %0d expected 1", mv_tot - mv0); end
    endtask

    task automatic test_zero_dead();
        int mv0, e0;
        restart();
        mv0 = mv_tot; e0 = seq_tot + ovl_tot;
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 5);
        drive(1'b0, 1'b1, 7);
        drive(1'b0, 1'b0, ENDT);
        checks++; if (die_a_cnt !== 2 + SYNC_LAT || pulse_a_cnt !== 32'd5) begin errors++;
            $display("FAIL zero_dead_a: die_a=%0d pulse_a=%0d expected %0d 5", die_a_cnt, pulse_a_cnt, 2 + SYNC_LAT); end
        checks++; if (die_b_cnt !== 32'd0 || pulse_b_cnt !== 32'd7) begin errors++;
            $display("FAIL zero_dead_b: die_b=%0d pulse_b=%0d expected 0 7", die_b_cnt, pulse_b_cnt); end
        checks++; if (mv_tot - mv0 !== 1 || seq_tot + ovl_tot - e0 !== 0) begin errors++;
            $display("FAIL zero_dead_strobes: mv=%0d err=%0d expected 1 0", mv_tot - mv0, seq_tot + ovl_tot - e0); end
    endtask

    task automatic test_overlap();
        int mv0, o0;
        restart();
        mv0 = mv_tot; o0 = ovl_tot;
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 3);
        drive(1'b1, 1'b1, 1);
        drive(1'b0, 1'b0, 1 + SYNC_LAT);
        checks++; if (overlap_err !== 1'b1 || die_a_cnt !== 2 + SYNC_LAT) begin errors++;
            $display("FAIL overlap_strobe: overlap_err=%b die_a=%0d expected 1 %0d", overlap_err, die_a_cnt, 2 + SYNC_LAT); end
        drive(1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 6);
        drive(1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, ENDT);
        checks++; if (ovl_tot - o0 !== 1 || mv_tot - mv0 !== 1) begin errors++;
            $display("FAIL overlap_counts: ovl=%0d mv=%0d expected 1 1", ovl_tot - o0, mv_tot - mv0); end
        checks++; if (die_a_cnt !== 4 + SYNC_LAT || pulse_a_cnt !== 32'd6 || die_b_cnt !== 32'd2 || pulse_b_cnt !== 32'd3) begin errors++;
            $display("FAIL overlap_next_frame: got %0d %0d %0d %0d expected %0d 6 2 3",
                     die_a_cnt, pulse_a_cnt, die_b_cnt, pulse_b_cnt, 4 + SYNC_LAT); end
    endtask

    task automatic test_seq_err();
        int mv0, s0;
        restart();
        mv0 = mv_tot; s0 = seq_tot;
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 4);
        drive(1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 4);
        drive(1'b0, 1'b0, ENDT);
        checks++; if (seq_tot - s0 !== 1 || mv_tot - mv0 !== 1) begin errors++;
            $display("FAIL seq_gap_b_counts: seq=%0d mv=%0d expected 1 1", seq_tot - s0, mv_tot - mv0); end
        checks++; if (die_a_cnt !== 32'd0 || pulse_a_cnt !== 32'd4 || die_b_cnt !== 32'd2 || pulse_b_cnt !== 32'd4) begin errors++;
            $display("FAIL seq_gap_b_frame: got %0d %0d %0d %0d expected 0 4 2 4",
                     die_a_cnt, pulse_a_cnt, die_b_cnt, pulse_b_cnt); end
        restart();
        s0 = seq_tot;
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, ENDT);
        checks++; if (seq_tot - s0 !== 1) begin errors++;
            $display("FAIL seq_gap_a_count: got %0d expected 1", seq_tot - s0); end
        checks++; if (die_a_cnt !== 32'd2 || pulse_a_cnt !== 32'd3 || die_b_cnt !== 32'd1 || pulse_b_cnt !== 32'd2) begin errors++;
            $display("FAIL seq_gap_a_frame: got %0d %0d %0d %0d expected 2 3 1 2",
                     die_a_cnt, pulse_a_cnt, die_b_cnt, pulse_b_cnt); end
    endtask

    task automatic test_saturation();
        int mv0, s0, s40;
        restart();
        io_en4 = 1'b1;
        mv0 = mv4_tot; s0 = sat_tot; s40 = sat4_tot;
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 20);
        drive(1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, ENDT);
        checks++; if (sat4_tot - s40 !== 1 || mv4_tot - mv0 !== 1) begin errors++;
            $display("FAIL sat_w4_counts: sat=%0d mv=%0d expected 1 1", sat4_tot - s40, mv4_tot - mv0); end
        checks++; if (d4_die_a !== 4'(2 + SYNC_LAT) || d4_pulse_a !== 4'd15 || d4_die_b !== 4'd2 || d4_pulse_b !== 4'd3) begin errors++;
            $display("FAIL sat_w4_frame: got %0d %0d %0d %0d expected %0d 15 2 3",
                     d4_die_a, d4_pulse_a, d4_die_b, d4_pulse_b, 2 + SYNC_LAT); end
        checks++; if (pulse_a_cnt !== 32'd20 || sat_tot - s0 !== 0) begin errors++;
            $display("FAIL sat_w32_frame: pulse_a=%0d sat=%0d expected 20 0", pulse_a_cnt, sat_tot - s0); end
        io_en4 = 1'b0;
    endtask

    task automatic test_level_and_en_drop();
        int mv0, e0;
        io_en = 1'b0;
        io_defaultLevel = 1'b1;
        drive(1'b0, 1'b0, 4);
        io_en = 1'b1;
        mv0 = mv_tot;
        drive(1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, ENDT);
        checks++; if (die_a_cnt !== 3 + SYNC_LAT || pulse_a_cnt !== 32'd10 || die_b_cnt !== 32'd3 || pulse_b_cnt !== 32'd10) begin errors++;
            $display("FAIL inverted_frame: got %0d %0d %0d %0d expected %0d 10 3 10",
                     die_a_cnt, pulse_a_cnt, die_b_cnt, pulse_b_cnt, 3 + SYNC_LAT); end
        checks++; if (mv_tot - mv0 !== 1) begin errors++;
            $display("FAIL inverted_mv: got %0d expected 1", mv_tot - mv0); end
        mv0 = mv_tot; e0 = seq_tot + ovl_tot + sat_tot;
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 4);
        io_en = 1'b0;
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 4);
        checks++; if (die_a_cnt !== 3 + SYNC_LAT || pulse_a_cnt !== 32'd10 || die_b_cnt !== 32'd3 || pulse_b_cnt !== 32'd10) begin errors++;
            $display("FAIL en_drop_hold: got %0d %0d %0d %0d expected %0d 10 3 10",
                     die_a_cnt, pulse_a_cnt, die_b_cnt, pulse_b_cnt, 3 + SYNC_LAT); end
        checks++; if (mv_tot - mv0 !== 0 || seq_tot + ovl_tot + sat_tot - e0 !== 0) begin errors++;
            $display("FAIL en_drop_strobes: mv=%0d err=%0d expected 0 0", mv_tot - mv0, seq_tot + ovl_tot + sat_tot - e0); end
        io_en = 1'b1;
        drive(1'b0, 1'b0, 1);
        drive(1'b1, 1'b0, 2);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, ENDT);
        checks++; if (die_a_cnt !== 1 + SYNC_LAT || pulse_a_cnt !== 32'd2 || die_b_cnt !== 32'd1 || pulse_b_cnt !== 32'd2) begin errors++;
            $display("FAIL en_drop_restart: got %0d %0d %0d %0d expected %0d 2 1 2",
                     die_a_cnt, pulse_a_cnt, die_b_cnt, pulse_b_cnt, 1 + SYNC_LAT); end
    endtask

    task automatic test_reset_midframe();
        restart();
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 3);
        io_rst = 1'b1;
        drive(1'b0, 1'b0, 1);
        checks++; if (die_a_cnt !== 32'd0 || pulse_a_cnt !== 32'd0 || die_b_cnt !== 32'd0 || pulse_b_cnt !== 32'd0) begin errors++;
            $display("FAIL midframe_reset: got %0d %0d %0d %0d expected 0 0 0 0",
                     die_a_cnt, pulse_a_cnt, die_b_cnt, pulse_b_cnt); end
        io_rst = 1'b0;
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 2);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, ENDT);
        checks++; if (die_a_cnt !== 2 + SYNC_LAT || pulse_a_cnt !== 32'd2 || die_b_cnt !== 32'd1 || pulse_b_cnt !== 32'd1) begin errors++;
            $display("FAIL midframe_recover: got %0d %0d %0d %0d expected %0d 2 1 1",
                     die_a_cnt, pulse_a_cnt, die_b_cnt, pulse_b_cnt, 2 + SYNC_LAT); end
    endtask

    initial begin
        io_rst          = 1'b1;
        io_en           = 1'b0;
        io_en4          = 1'b0;
        io_defaultLevel = 1'b0;
        io_pulseIn_a    = 1'b0;
        io_pulseIn_b    = 1'b0;
        @(negedge io_clk);
        test_reset();
        test_basic_frame();
        test_zero_dead();
        test_overlap();
        test_seq_err();
        test_saturation();
        test_level_and_en_drop();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
